// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path:
// state encoding, opcodes, ALU operation classes and mux selects.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h1;
    localparam logic [3:0] OP_SW   = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_J    = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] OPS_SUB  = 3'b001;
    localparam logic [2:0] OPS_ADD  = 3'b010;
    localparam logic [2:0] OPS_FUNC = 3'b100;

    localparam logic [1:0] SRC_B_RT  = 2'b00;
    localparam logic [1:0] SRC_B_ONE = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that hold a memory request open and are guarded by the timer
    function automatic logic is_req(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits without mem_ready and flags
// the last permitted cycle so the FSM can abort with a bus error.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (busy && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle CPU control unit: Moore FSM driving datapath enables and
// selects, with a bounded memory wait and sticky halt/error flags.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] ops,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic [1:0] pc_src,
    output logic       halted,
    output logic       illegal,
    output logic       bus_error
);

    state_t     state;
    state_t     state_n;
    logic [3:0] op_q;
    logic       set_illegal;
    logic       req_state;
    logic       expired;
    logic       timeout;
    logic       clear;
    logic       zero_unused;

    // zero gates the PC load in the datapath; the FSM only raises pc_write_cond
    assign zero_unused = zero;

    assign req_state = is_req(state);
    assign timeout   = req_state && !mem_ready && expired;
    assign clear     = (state_n != state);

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .busy   (req_state && !mem_ready),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            op_q      <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (timeout) begin
                bus_error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        set_illegal   = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RT;
        ops           = OPS_ADD;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        pc_src        = PC_ALU;
        halted        = 1'b0;

        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_ONE;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end else if (timeout) begin
                    state_n = S_HALT;
                end
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_R:         state_n = S_EXEC_R;
                    OP_LW, OP_SW: state_n = S_ADDR;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_J:         state_n = S_JUMP;
                    OP_ADDI:      state_n = S_EXEC_I;
                    OP_HALT:      state_n = S_HALT;
                    default: begin
                        set_illegal = 1'b1;
                        state_n     = S_HALT;
                    end
                endcase
            end
            S_EXEC_R: begin
                ops       = OPS_FUNC;
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_RT;
                state_n   = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_n   = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = (op_q == OP_R);
                state_n   = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_n   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_n = S_WB_MEM;
                end else if (timeout) begin
                    state_n = S_HALT;
                end
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_n = S_FETCH;
                end else if (timeout) begin
                    state_n = S_HALT;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_n    = S_FETCH;
            end
            S_BRANCH: begin
                ops           = OPS_SUB;
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_RT;
                pc_write_cond = 1'b1;
                pc_src        = PC_BRANCH;
                state_n       = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                state_n  = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_n = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench: builds a per-cycle stimulus/expectation trace from the
// instruction-level rules, then replays it against the control unit.
module tb_cpu_control_fsm;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, ir_write, pc_write, pc_write_cond;
    logic       reg_write, alu_src_a, mem_to_reg, reg_dst;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] ops;
    logic       halted, illegal, bus_error;

    always #5 clk = ~clk;

    cpu_control_fsm #(
        .TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .ops          (ops),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .pc_src       (pc_src),
        .halted       (halted),
        .illegal      (illegal),
        .bus_error    (bus_error)
    );

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] ops;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] pc_src;
        logic       halted;
        logic       illegal;
        logic       bus_error;
    } out_t;

    typedef struct {
        logic       r;
        logic       rdy;
        logic [3:0] op;
        logic       z;
        logic       chk;
        out_t       e;
    } cyc_t;

    cyc_t       q[$];
    bit         m_ill, m_bus, m_halt, noise;
    logic [3:0] cur_op = 4'h0;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic out_t base();
        out_t o;
        o = '0;
        o.ops = 3'b010;
        return o;
    endfunction

    function automatic out_t fetch_o(bit rdy);
        out_t o;
        o = base();
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        o.ir_write  = rdy;
        o.pc_write  = rdy;
        return o;
    endfunction

    task automatic push(bit r, bit rdy, bit z, out_t e, bit chk = 1'b1);
        cyc_t c;
        e.halted    = m_halt;
        e.illegal   = m_ill;
        e.bus_error = m_bus;
        c.r = r; c.rdy = rdy; c.op = cur_op; c.z = z; c.chk = chk; c.e = e;
        q.push_back(c);
    endtask

    task automatic fetch_ok(int n);
        repeat (n) push(1'b0, 1'b0, noise, fetch_o(1'b0));
        push(1'b0, 1'b1, noise, fetch_o(1'b1));
    endtask

    task automatic decode(logic [3:0] op);
        cur_op = op;
        push(1'b0, noise, noise, base());
    endtask

    task automatic halt_cycles(int n);
        repeat (n) push(1'b0, noise, noise, base());
    endtask

    task automatic mem_wait(int n, bit rd);
        out_t o;
        o = base();
        if (rd) o.mem_read = 1'b1;
        else o.mem_write = 1'b1;
        repeat (n) push(1'b0, 1'b0, noise, o);
        push(1'b0, 1'b1, noise, o);
    endtask

    task automatic wb(bit rdst, bit mem);
        out_t o;
        o = base();
        o.reg_write  = 1'b1;
        o.reg_dst    = rdst;
        o.mem_to_reg = mem;
        push(1'b0, noise, noise, o);
    endtask

    task automatic addr();
        out_t o;
        o = base();
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10;
        push(1'b0, noise, noise, o);
    endtask

    task automatic do_reset(out_t cur);
        push(1'b1, 1'b0, noise, cur);
        m_ill = 0; m_bus = 0; m_halt = 0;
    endtask

    task automatic instr(logic [3:0] op, int fw, int mw, bit z);
        out_t o;
        noise = ~noise;
        fetch_ok(fw);
        decode(op);
        o = base();
        case (op)
            OP_R: begin
                o.ops = 3'b100; o.alu_src_a = 1'b1;
                push(1'b0, noise, noise, o);
                wb(1'b1, 1'b0);
            end
            OP_ADDI: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(1'b0, noise, noise, o);
                wb(1'b0, 1'b0);
            end
            OP_LW: begin
                addr(); mem_wait(mw, 1'b1); wb(1'b0, 1'b1);
            end
            OP_SW: begin
                addr(); mem_wait(mw, 1'b0);
            end
            OP_BEQ: begin
                o.ops = 3'b001; o.alu_src_a = 1'b1;
                o.pc_write_cond = 1'b1; o.pc_src = 2'b01;
                push(1'b0, noise, z, o);
            end
            OP_J: begin
                o.pc_write = 1'b1; o.pc_src = 2'b10;
                push(1'b0, noise, noise, o);
            end
            OP_HALT: begin
                m_halt = 1; halt_cycles(3);
            end
            default: begin
                m_ill = 1; m_halt = 1; halt_cycles(20);
            end
        endcase
    endtask

    initial begin
        int   s;
        int   cnt_a, cnt_b;
        int   dut_pcload, dut_rw;
        out_t o, g;

        push(1'b1, 1'b0, 1'b0, base(), 1'b0);

        s = q.size();
        instr(OP_R, 1, 0, 1'b0);
        check("pin_r_len", q.size() - s, 5);
        check("pin_r_ops", q[s+3].e.ops, 3'b100);
        check("pin_r_wb", {q[s+4].e.reg_write, q[s+4].e.reg_dst}, 2'b11);

        s = q.size();
        instr(OP_LW, 0, 3, 1'b0);
        cnt_a = 0; cnt_b = 0;
        for (int i = s; i < q.size(); i++) begin
            if (q[i].e.mem_read) cnt_a++;
            if (q[i].e.reg_write && q[i].e.mem_to_reg) cnt_b++;
        end
        check("pin_lw_memread", cnt_a, 5);
        check("pin_lw_wbmem", cnt_b, 1);

        instr(OP_BEQ, 0, 0, 1'b1);
        instr(OP_BEQ, 1, 0, 1'b0);
        instr(OP_ADDI, 0, 0, 1'b0);
        instr(OP_J, 0, 0, 1'b0);
        instr(OP_SW, 0, 0, 1'b0);
        instr(4'h7, 0, 0, 1'b0);
        do_reset(base());

        noise = ~noise;
        fetch_ok(2);
        decode(OP_SW);
        addr();
        o = base();
        o.mem_write = 1'b1;
        repeat (5) push(1'b0, 1'b0, noise, o);
        do_reset(o);
        instr(OP_R, 0, 0, 1'b0);

        s = q.size();
        fetch_ok(0);
        decode(OP_SW);
        addr();
        repeat (16) push(1'b0, 1'b0, noise, o);
        m_bus = 1; m_halt = 1;
        halt_cycles(4);
        cnt_a = 0;
        for (int i = s; i < q.size(); i++) if (q[i].e.mem_write) cnt_a++;
        check("pin_sw_timeout_len", cnt_a, 16);
        do_reset(base());

        instr(OP_HALT, 0, 0, 1'b0);
        do_reset(base());

        repeat (16) push(1'b0, 1'b0, noise, fetch_o(1'b0));
        m_bus = 1; m_halt = 1;
        halt_cycles(2);
        do_reset(base());
        instr(OP_LW, 1, 1, 1'b0);

        dut_pcload = 0;
        dut_rw = 0;
        foreach (q[i]) begin
            @(negedge clk);
            rst       = q[i].r;
            mem_ready = q[i].rdy;
            opcode    = q[i].op;
            zero      = q[i].z;
            #1;
            if (q[i].chk) begin
                g.mem_read      = mem_read;
                g.mem_write     = mem_write;
                g.ir_write      = ir_write;
                g.pc_write      = pc_write;
                g.pc_write_cond = pc_write_cond;
                g.reg_write     = reg_write;
                g.alu_src_a     = alu_src_a;
                g.alu_src_b     = alu_src_b;
                g.ops           = ops;
                g.mem_to_reg    = mem_to_reg;
                g.reg_dst       = reg_dst;
                g.pc_src        = pc_src;
                g.halted        = halted;
                g.illegal       = illegal;
                g.bus_error     = bus_error;
                check($sformatf("cycle%0d", i), 32'(g), 32'(q[i].e));
                if (pc_write_cond && zero) dut_pcload++;
                if (reg_write) dut_rw++;
            end
        end

        @(negedge clk);
        check("pc_load_count", dut_pcload, 1);
        check("reg_write_count", dut_rw, 5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for mem_ready before a bus error.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  4  IR[15:12]; sampled in DECODE.
REQ-005 zero  input  1  ALU zero flag; sampled in BRANCH.
REQ-006 mem_ready  input  1  memory completion strobe for the current mem_read or mem_write.
REQ-007 mem_read, mem_write  output  1 each  memory request, held until accepted.
REQ-008 ir_write, pc_write, pc_write_cond, reg_write  output  1 each  register-file, IR and PC enables.
REQ-009 alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs.
REQ-010 alu_src_b  output  2  ALU B select: 00 = rt, 01 = const 1, 10 = sign-extended immediate.
REQ-011 ops  output  3  ALU-control operation class, one-hot: 001 = subtract, 010 = add, 100 = R-type (use func).
REQ-012 mem_to_reg, reg_dst  output  1 each  write-back data select and destination select.
REQ-013 pc_src  output  2  PC select: 00 = ALU result, 01 = branch target, 10 = jump target.
REQ-014 halted, illegal, bus_error  output  1 each  sticky status flags.

Function
REQ-015 States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH, JUMP, HALT.
REQ-016 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, ops=010; on mem_ready pulse ir_write=1 and pc_write=1 (PC+1) for one cycle, then go to DECODE.
REQ-017 DECODE, one cycle: 0000 -> EXEC_R; 0001 or 0010 -> ADDR; 0011 -> BRANCH; 0100 -> JUMP; 0101 -> EXEC_I; 1111 -> HALT; any other opcode -> set illegal, then HALT.
REQ-018 EXEC_R: ops=100, alu_src_a=1, alu_src_b=00, then WB_R. EXEC_I: ops=010, alu_src_b=10, then WB_R with reg_dst=0.
REQ-019 WB_R: reg_write=1 and mem_to_reg=0 for exactly one cycle; reg_dst=1 for R-type, 0 for ADDI; then FETCH.
REQ-020 ADDR: ops=010, alu_src_a=1, alu_src_b=10; go to MEM_RD for 0001 and MEM_WR for 0010.
REQ-021 MEM_RD/MEM_WR: hold mem_read or mem_write at 1 until mem_ready; MEM_RD then goes to WB_MEM (reg_write=1, mem_to_reg=1, one cycle), MEM_WR goes to FETCH.
REQ-022 BRANCH: ops=001, alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_src=01; PC loads only if zero=1; then FETCH.
REQ-023 JUMP: pc_write=1 and pc_src=10 for one cycle, then FETCH.
REQ-024 ops SHALL be exactly one-hot in every state and never 000; states that do not use the ALU drive 010.
REQ-025 All enables and requests not named for a state SHALL be 0 in that state; outputs are Moore (decoded from the state register), except the mem_ready-qualified pulses in FETCH.
REQ-026 The wait counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle a request is outstanding without mem_ready.
REQ-027 When the counter reaches TIMEOUT-1 with no mem_ready, bus_error is set, the request drops and the state goes to HALT on the next cycle.
REQ-028 mem_ready asserted while no request is outstanding SHALL be ignored.
REQ-029 HALT is absorbing: all enables and requests are 0, halted=1, and only rst exits it.

Reset
REQ-030 When rst=1 at a clock edge, state=FETCH, the counter clears, and halted, illegal and bus_error clear; mem_read=1 (the FETCH request) is the only asserted output after reset.
REQ-031 rst SHALL take precedence over every transition, including mid-memory-wait and inside HALT; an outstanding write is abandoned without a reg_write or pc_write pulse.

Structure
REQ-032 A shared package cpu_pkg SHALL hold the state enumeration, opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT) and the ops encodings (OPS_SUB, OPS_ADD, OPS_FUNC).
REQ-033 One sub-module, mem_wait_timer (counter plus timeout compare, parameter TIMEOUT), is natural; everything else stays flat.

Verification
REQ-034 R-type 0x0 with mem_ready on the 2nd FETCH cycle -> states FETCH, FETCH, DECODE, EXEC_R, WB_R; ops=100 in EXEC_R; one reg_write pulse with reg_dst=1.
REQ-035 LW 0x1 with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles; WB_MEM gives reg_write=1 and mem_to_reg=1 for exactly one cycle.
REQ-036 BEQ 0x3 with zero=1, then with zero=0 -> both give pc_write_cond=1, pc_src=01 and ops=001; the PC-load enable (pc_write_cond AND zero) is 1 only in the zero=1 case.
REQ-037 Opcode 0x7 -> illegal=1 and halted=1 one cycle after DECODE; all enables stay 0 for 20 further cycles.
REQ-038 SW with mem_ready never asserted, TIMEOUT=16 -> mem_write drops and bus_error=1 after 16 cycles; state is HALT.
REQ-039 rst pulsed during a MEM_WR wait and during HALT -> FETCH next cycle, flags clear, and no write-back or PC pulse occurs.
